// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampling baud-tick generator, two-flop RXD
// synchroniser, three-sample majority-vote bit sampler and frame FSM with
// configurable data width, parity mode and stop-bit count.
module uart_rx_param #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BUSY,
  output logic [2:0]           fsm_state
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_S0     = OW'(M - 1);
  localparam logic [OW-1:0] OS_S1     = OW'(M);
  localparam logic [OW-1:0] OS_S2     = OW'(M + 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx_param: CLK_FREQ / (BAUD_RATE * OVERSAMPLE) must be >= 1");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
      $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
      $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_par_check
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Expected parity bit for the received word (odd mode inverts the XOR).
  function automatic logic parity_expected(input logic [DATA_BITS-1:0] d);
    logic x;
    x = ^d;
    if (PARITY == 1) begin
      return ~x;
    end else begin
      return x;
    end
  endfunction

  // Two-of-three majority vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state;
  state_t                 state_next;
  logic                   sync1;
  logic                   rxd_s;
  logic                   rxd_d;
  logic [DW-1:0]          div_cnt;
  logic                   tick;
  logic [OW-1:0]          os_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [2:0]             samp;
  logic [DATA_BITS-1:0]   shreg;
  logic                   stop_cnt;
  logic                   par_bad;
  logic                   frm_bad;
  logic                   bit_end;
  logic                   mid_last;
  logic                   bit_val;
  logic                   stop_final;
  logic                   start_edge;
  logic                   data_last;
  logic                   stop_done;
  logic                   busy;

  // Two-flop synchroniser on the raw pin plus a delay flop for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      sync1 <= RXD;
      rxd_s <= sync1;
      rxd_d <= rxd_s;
    end
  end

  // Free-running baud divider producing one oversample tick every DIV cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= {DW{1'b0}};
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= {DW{1'b0}};
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Tick strobes and the voted bit value; the third vote is taken live from
  // rxd_s on the M+1 tick so the final stop bit can conclude mid-bit.
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    bit_end  = tick && (os_cnt == OS_LAST);
    mid_last = tick && (os_cnt == OS_S2);
    if (os_cnt == OS_S2) begin
      bit_val = majority3(samp[0], samp[1], rxd_s);
    end else begin
      bit_val = majority3(samp[0], samp[1], samp[2]);
    end
    if (STOP_BITS == 2) begin
      stop_final = stop_cnt;
    end else begin
      stop_final = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_next = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (bit_val) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
          end
        end else begin
          state_next = S_START;
        end
      end
      S_DATA: begin
        if (data_last) begin
          if (PARITY != 0) begin
            state_next = S_PARITY;
          end else begin
            state_next = S_STOP;
          end
        end else begin
          state_next = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
        end else begin
          state_next = S_PARITY;
        end
      end
      S_STOP: begin
        if (stop_done && stop_final) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_STOP;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM output decode: busy flag and frame-event strobes for the datapath.
  always_comb begin
    busy       = (state != S_IDLE);
    start_edge = rxd_d & ~rxd_s;
    data_last  = bit_end && (bit_cnt == BITS_LAST);
    if (state == S_STOP) begin
      if (stop_final) begin
        stop_done = mid_last;
      end else begin
        stop_done = bit_end;
      end
    end else begin
      stop_done = 1'b0;
    end
  end

  // Receive datapath: bit timing, sampling, shift register, error flags and
  // registered outputs that only change when a frame completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      os_cnt     <= {OW{1'b0}};
      bit_cnt    <= {BW{1'b0}};
      samp       <= 3'b111;
      shreg      <= {DATA_BITS{1'b0}};
      stop_cnt   <= 1'b0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      DATA_OUT   <= {DATA_BITS{1'b0}};
      DATA_VALID <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;

      if (state == S_IDLE) begin
        os_cnt  <= {OW{1'b0}};
        bit_cnt <= {BW{1'b0}};
        if (start_edge) begin
          stop_cnt <= 1'b0;
          par_bad  <= 1'b0;
          frm_bad  <= 1'b0;
        end
      end else if (tick) begin
        if (os_cnt == OS_LAST) begin
          os_cnt <= {OW{1'b0}};
        end else begin
          os_cnt <= os_cnt + OW'(1);
        end
        if (os_cnt == OS_S0) begin
          samp[0] <= rxd_s;
        end
        if (os_cnt == OS_S1) begin
          samp[1] <= rxd_s;
        end
        if (os_cnt == OS_S2) begin
          samp[2] <= rxd_s;
        end
      end

      if ((state == S_DATA) && bit_end) begin
        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end

      if ((state == S_PARITY) && bit_end) begin
        par_bad <= (bit_val != parity_expected(shreg));
      end

      if (stop_done) begin
        stop_cnt <= ~stop_cnt;
        frm_bad  <= frm_bad | ~bit_val;
        if (stop_final) begin
          DATA_VALID <= 1'b1;
          DATA_OUT   <= shreg;
          PARITY_ERR <= par_bad;
          FRAME_ERR  <= frm_bad | ~bit_val;
        end
      end
    end
  end

  assign BUSY      = busy;
  assign fsm_state = state;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It replaces the fixed 8N1 receive controller that takes external oversample and bit-count "done" strobes. The block contains its own oversampling baud-tick generator, RXD synchroniser, majority-vote bit sampler and frame FSM. It supports configurable data width, parity mode and stop-bit count, and reports parity and framing errors. It sits between the board RXD pin and the byte consumer (FIFO or register bank).

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bit/s.
OVERSAMPLE, 16, ticks per bit; even, >= 8.
DATA_BITS, 8, data bits per frame; 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous, active-high reset.
RXD  in  1  asynchronous serial input; idle high.
DATA_OUT  out  DATA_BITS  last received word, LSB = first data bit.
DATA_VALID  out  1  one-cycle strobe when a frame completes.
PARITY_ERR  out  1  parity mismatch on the last frame.
FRAME_ERR  out  1  a stop bit was sampled low on the last frame.
BUSY  out  1  high whenever fsm_state != IDLE.
fsm_state  out  3  current state encoding, for debug.

Behaviour:
- Interface: one clock, CLK. RST is synchronous and active-high. All flops are updated only on the CLK rising edge.
- Constants:
  - DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE), integer division. DIV must be >= 1; an elaboration check fails otherwise.
  - M = OVERSAMPLE / 2.
- Synchroniser: RXD passes through 2 flops to give rxd_s. Both flops reset to 1. One further flop, rxd_d, is used for falling-edge detection.
- Tick generator:
  - Free-running counter 0..DIV-1; tick = 1 for one cycle when the count equals DIV-1.
  - The counter resets to 0.
  - With DIV = 1, tick is high every cycle.
- Bit timing:
  - os_cnt counts ticks 0..OVERSAMPLE-1 within each bit.
  - On ticks where os_cnt is M-1, M or M+1, the sampler captures rxd_s.
  - bit_val is the majority of those 3 samples.
- FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. fsm_state resets to IDLE.
  - IDLE: when rxd_d=1 and rxd_s=0, go to START; clear os_cnt and bit_cnt.
  - START: on the tick where os_cnt = OVERSAMPLE-1:
    - bit_val = 1: false start, return to IDLE; no strobe, flags unchanged.
    - bit_val = 0: go to DATA; os_cnt wraps to 0.
  - DATA: at each bit end (os_cnt = OVERSAMPLE-1 tick):
    - Shift bit_val into the shift register at the MSB end, shifting right (LSB-first line order).
    - Increment bit_cnt.
    - After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: at bit end, compute the expected parity over the shifted data.
    - Even mode: XOR of data. Odd mode: inverted XOR of data.
    - Latch par_bad = (bit_val != expected). Go to STOP.
  - STOP: each stop bit is sampled.
    - Non-final stop bits conclude at the os_cnt = OVERSAMPLE-1 tick.
    - The final stop bit concludes at the os_cnt = M+1 tick, not at bit end, so that a back-to-back start edge is not missed.
    - Any stop bit_val = 0 sets frm_bad.
    - On the final stop-bit conclusion, go to IDLE.
- Output update, in the cycle after the final stop conclusion:
  - DATA_VALID = 1 for exactly one cycle.
  - DATA_OUT, PARITY_ERR and FRAME_ERR update in the same cycle and hold until the next completed frame.
  - par_bad and frm_bad clear at START entry.
  - Errored frames still strobe DATA_VALID, with the data presented.
- Reset values: DATA_OUT=0, DATA_VALID=0, PARITY_ERR=0, FRAME_ERR=0, BUSY=0, fsm_state=0.
- Reset mid-frame: in the next cycle the FSM is in IDLE, the partial word is discarded, and no strobe is produced. Reception resumes on the next falling edge after RST deasserts.
- A low RXD held across IDLE without a new falling edge does not restart reception. A falling edge is required.
- Latency: DATA_VALID rises (M+2)*DIV + 3 cycles ±1 tick after the final stop bit's leading edge at the RXD pin.

Test Plan:
Benches use CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 (DIV=1), driving 16-cycle bits unless noted.
1. 8N1, send 0xA5 -> exactly one DATA_VALID pulse; DATA_OUT=8'hA5, PARITY_ERR=0, FRAME_ERR=0; fsm_state returns to 0.
2. PARITY=2:
   - Send 0x3C with parity bit 0 -> DATA_OUT=8'h3C, PARITY_ERR=0.
   - Resend with parity bit 1 -> DATA_OUT=8'h3C, PARITY_ERR=1, DATA_VALID still pulses.
3. 8N1, send 0x0F with the stop bit held 0 -> DATA_OUT=8'h0F, FRAME_ERR=1. The next clean frame 0x10 -> FRAME_ERR=0.
4. RXD low for 5 cycles, then high -> fsm_state goes 0 -> 1 -> 0; no DATA_VALID; all outputs unchanged.
5. Back-to-back frames 0x55 and 0xAA with no idle gap -> two DATA_VALID pulses 160 cycles apart, DATA_OUT 8'h55 then 8'hAA.
6. DATA_BITS=7, STOP_BITS=2, PARITY=1:
   - Send 7'h41: DATA_OUT=7'h41, no errors.
   - Assert RST for 1 cycle during data bit 3: next cycle fsm_state=0 and all outputs 0. A following 7'h12 frame is received correctly.
